perceptron: RTL and testbench

Single-neuron compute block for the MNIST FPGA network. Weights (one per input pixel) are loaded through an AXI4-Lite slave into internal weight RAM. Each inference streams N_INPUTS samples in and computes a 64-bit dot product plus bias, then presents a ReLU-clamped 32-bit activation with a done flag. It sits between the input-vector stream source and the next layer's activation consumer.

---
 rtl/perceptron.sv | 140 ++++++++++++++
 tb/tb_perceptron.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/perceptron.sv
// perceptron: weight RAM loaded over AXI4-Lite, streamed signed 32x32 MAC into a 64-bit
// accumulator, ReLU-clamped 32-bit activation presented with a done flag.
module perceptron #(
    parameter int N_INPUTS = 784,
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 12
) (
    input  logic                  s_axi_aclk,
    input  logic                  s_axi_areset,
    input  logic [ADDR_W-1:0]     s_axi_awaddr,
    input  logic [2:0]            s_axi_awprot,
    input  logic                  s_axi_awvalid,
    output logic                  s_axi_awready,
    input  logic [DATA_W-1:0]     s_axi_wdata,
    input  logic [DATA_W/8-1:0]   s_axi_wstrb,
    input  logic                  s_axi_wvalid,
    output logic                  s_axi_wready,
    output logic [1:0]            s_axi_bresp,
    output logic                  s_axi_bvalid,
    input  logic                  s_axi_bready,
    input  logic [ADDR_W-1:0]     s_axi_araddr,
    input  logic [2:0]            s_axi_arprot,
    input  logic                  s_axi_arvalid,
    output logic                  s_axi_arready,
    output logic [DATA_W-1:0]     s_axi_rdata,
    output logic [1:0]            s_axi_rresp,
    output logic                  s_axi_rvalid,
    input  logic                  s_axi_rready,
    input  logic                  start,
    input  logic [DATA_W-1:0]     x_tdata,
    input  logic                  x_tvalid,
    output logic                  x_tready,
    input  logic [DATA_W-1:0]     bias,
    output logic [DATA_W-1:0]     a_tdata,
    output logic                  done
);
    localparam int IDX_W = ADDR_W - 2;
    localparam int CNT_W = $clog2(N_INPUTS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_INPUTS - 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_INPUTS - 1);
    localparam logic [DATA_W-1:0] A_MAX = {1'b0, {(DATA_W-1){1'b1}}};

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t state, state_next;

    logic [DATA_W-1:0]           mem [N_INPUTS];
    logic [IDX_W-1:0]            wr_idx, rd_idx;
    logic                        wr_in, rd_in, wr_req, rd_req, wr_en;
    logic [CNT_W-1:0]            cnt;
    logic                        beat, last_beat;
    logic signed [2*DATA_W-1:0]  prod, acc;
    logic                        prod_v, prod_first, prod_last, acc_last;
    logic [DATA_W-1:0]           bias_r, w_cur, clamp;
    logic                        unused_ok;

    assign unused_ok = ^{s_axi_awprot, s_axi_arprot, s_axi_awaddr[1:0], s_axi_araddr[1:0]};

    assign wr_idx = s_axi_awaddr[ADDR_W-1:2];
    assign rd_idx = s_axi_araddr[ADDR_W-1:2];
    assign wr_in  = wr_idx <= LAST_IDX;
    assign rd_in  = rd_idx <= LAST_IDX;
    assign wr_req = s_axi_awvalid & s_axi_wvalid & ~s_axi_bvalid & ~s_axi_awready;
    assign rd_req = s_axi_arvalid & ~s_axi_rvalid & ~s_axi_arready;
    assign wr_en  = s_axi_awready & s_axi_awvalid & s_axi_wvalid & wr_in;
    assign s_axi_bresp = 2'b00;
    assign s_axi_rresp = 2'b00;

    // Out-of-range writes still handshake and respond OKAY, they just never reach the RAM.
    always_ff @(posedge s_axi_aclk)
        if (wr_en)
            for (int b = 0; b < DATA_W / 8; b++)
                if (s_axi_wstrb[b]) mem[CNT_W'(wr_idx)][8*b +: 8] <= s_axi_wdata[8*b +: 8];

    always_ff @(posedge s_axi_aclk or posedge s_axi_areset)
        if (s_axi_areset) begin
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b0;
            s_axi_bvalid  <= 1'b0;
            s_axi_arready <= 1'b0;
            s_axi_rvalid  <= 1'b0;
            s_axi_rdata   <= '0;
        end else begin
            s_axi_awready <= wr_req;
            s_axi_wready  <= wr_req;
            s_axi_arready <= rd_req;
            if (s_axi_awready) s_axi_bvalid <= 1'b1;
            else if (s_axi_bready) s_axi_bvalid <= 1'b0;
            if (s_axi_arready) begin
                s_axi_rvalid <= 1'b1;
                s_axi_rdata  <= rd_in ? mem[CNT_W'(rd_idx)] : '0;
            end else if (s_axi_rready) s_axi_rvalid <= 1'b0;
        end

    assign x_tready  = state == RUN;
    assign beat      = x_tvalid & x_tready;
    assign last_beat = beat & (cnt == LAST_CNT);
    assign w_cur     = mem[cnt];
    assign clamp     = acc[2*DATA_W-1] ? '0 : (|acc[2*DATA_W-2:DATA_W-1]) ? A_MAX : acc[DATA_W-1:0];

    always_comb begin
        state_next = state;
        case (state)
            IDLE:  state_next = start ? RUN : IDLE;
            RUN:   state_next = last_beat ? DRAIN : RUN;
            DRAIN: state_next = acc_last ? DONE : DRAIN;
            DONE:  state_next = start ? RUN : DONE;
        endcase
    end

    // Product stage then accumulate stage; acc_last marks the final sum one cycle before DONE.
    always_ff @(posedge s_axi_aclk or posedge s_axi_areset)
        if (s_axi_areset) begin
            state      <= IDLE;
            cnt        <= '0;
            prod       <= '0;
            prod_v     <= 1'b0;
            prod_first <= 1'b0;
            prod_last  <= 1'b0;
            bias_r     <= '0;
            acc        <= '0;
            acc_last   <= 1'b0;
            a_tdata    <= '0;
            done       <= 1'b0;
        end else begin
            state      <= state_next;
            prod_v     <= beat;
            prod_first <= beat & (cnt == '0);
            prod_last  <= last_beat;
            acc_last   <= prod_v & prod_last;
            done       <= state_next == DONE;
            if (beat) begin
                prod <= (2*DATA_W)'($signed(w_cur)) * (2*DATA_W)'($signed(x_tdata));
                cnt  <= last_beat ? '0 : cnt + 1'b1;
                if (cnt == '0) bias_r <= bias;
            end
            if (prod_v) acc <= prod_first ? (2*DATA_W)'($signed(bias_r)) + prod : acc + prod;
            if (state == DRAIN && state_next == DONE) a_tdata <= clamp;
        end
endmodule

// File: tb/tb_perceptron.sv
// tb_perceptron: directed scenarios for AXI weight loading, inference, back-to-back runs,
// mid-run reset and activation clamping.
module tb_perceptron;
    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] awaddr, araddr;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;
    logic        start, x_tvalid, x_tready, done;
    logic [31:0] x_tdata, bias, a_tdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    perceptron dut (
        .s_axi_aclk(clk), .s_axi_areset(rst),
        .s_axi_awaddr(awaddr), .s_axi_awprot(3'b000), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
        .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
        .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
        .s_axi_araddr(araddr), .s_axi_arprot(3'b000), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
        .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
        .start(start), .x_tdata(x_tdata), .x_tvalid(x_tvalid), .x_tready(x_tready),
        .bias(bias), .a_tdata(a_tdata), .done(done)
    );

    task automatic axi_write(input logic [11:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             output logic [1:0] resp);
        int n = 0;
        @(negedge clk);
        awaddr = addr; wdata = data; wstrb = strb; awvalid = 1'b1; wvalid = 1'b1;
        while (!awready && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) begin
            checks++; errors++;
            $display("FAIL axi_write_timeout addr=%h awready=%b required 1", addr, awready);
        end
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        resp = bvalid ? bresp : 2'bxx;
    endtask

    task automatic axi_read(input logic [11:0] addr, output logic [31:0] data, output logic [1:0] resp);
        int n = 0;
        @(negedge clk);
        araddr = addr; arvalid = 1'b1;
        while (!arready && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) begin
            checks++; errors++;
            $display("FAIL axi_read_timeout addr=%h arready=%b required 1", addr, arready);
        end
        @(posedge clk); #1;
        arvalid = 1'b0;
        data = rvalid ? rdata : 32'hxxxxxxxx;
        resp = rvalid ? rresp : 2'bxx;
    endtask

    task automatic load_weights(input logic [31:0] base, input logic [31:0] step, output int bad);
        logic [1:0] r;
        bad = 0;
        for (int i = 0; i < 784; i++) begin
            axi_write(12'(i * 4), base + step * 32'(i), 4'hF, r);
            if (r !== 2'b00) bad++;
        end
    endtask

    // Streams x with start held until done is seen; returns beat count, last-beat-to-done
    // latency in cycles, and done/a_tdata as seen on the first accepted beat.
    task automatic run_stream(input logic [31:0] b, input logic [31:0] x, output int beats, output int lat,
                              output logic done_first, output logic [31:0] a_first);
        int last = 0;
        bias = b; x_tdata = x; start = 1'b1; x_tvalid = 1'b1;
        beats = 0; lat = -1; done_first = 1'bx; a_first = 'x;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            @(negedge clk);
            if (done && beats > 0) begin lat = cyc - last; break; end
            if (x_tvalid && x_tready) begin
                if (beats == 0) begin done_first = done; a_first = a_tdata; end
                beats++; last = cyc;
            end
        end
        if (lat < 0) begin
            checks++; errors++;
            $display("FAIL run_timeout beats=%0d done=%b required done within 2000 cycles", beats, done);
        end
    endtask

    task automatic test_reset();
        logic [31:0] d;
        logic [1:0]  r;
        int bad = 0;
        rst = 1'b1;
        repeat (30) begin
            @(negedge clk);
            if ({awready, wready, bvalid, arready, rvalid, x_tready, done} !== 7'b0 ||
                a_tdata !== 32'h0 || rdata !== 32'h0) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL reset_outputs cycles_nonzero=%0d required 0", bad); end
        checks++;
        if (dut.acc !== 64'h0) begin errors++; $display("FAIL reset_acc got=%h required 0", dut.acc); end
        rst = 1'b0;
        axi_read(12'h000, d, r);
        checks++;
        if (r !== 2'b00) begin errors++; $display("FAIL reset_read_resp got=%b required 00", r); end
    endtask

    task automatic test_axi();
        logic [31:0] d;
        logic [1:0]  r;
        int bad;
        int idx [10] = '{0, 1, 5, 99, 255, 256, 400, 511, 700, 783};
        load_weights(32'd1, 32'd1, bad);
        checks++;
        if (bad != 0) begin errors++; $display("FAIL write_resp bad=%0d required 0", bad); end
        foreach (idx[j]) begin
            axi_read(12'(idx[j] * 4), d, r);
            checks++;
            if (d !== 32'(idx[j] + 1) || r !== 2'b00) begin
                errors++;
                $display("FAIL readback idx=%0d got=%h resp=%b required %h resp=00", idx[j], d, r, idx[j] + 1);
            end
        end
        axi_read(12'h00E, d, r);
        checks++;
        if (d !== 32'd4) begin errors++; $display("FAIL unaligned_read got=%h required 4", d); end
        axi_write(12'h014, 32'hABCD1234, 4'b0011, r);
        axi_read(12'h014, d, r);
        checks++;
        if (d !== 32'h00001234) begin errors++; $display("FAIL strobe_low got=%h required 00001234", d); end
        axi_write(12'h014, 32'h55660000, 4'b1100, r);
        axi_read(12'h014, d, r);
        checks++;
        if (d !== 32'h55661234) begin errors++; $display("FAIL strobe_high got=%h required 55661234", d); end
        axi_write(12'h014, 32'd6, 4'hF, r);
        axi_write(12'hC40, 32'hDEADBEEF, 4'hF, r);
        checks++;
        if (r !== 2'b00) begin errors++; $display("FAIL oor_write_resp got=%b required 00", r); end
        axi_read(12'hC40, d, r);
        checks++;
        if (d !== 32'h0 || r !== 2'b00) begin
            errors++; $display("FAIL oor_read got=%h resp=%b required 0 resp=00", d, r);
        end
        axi_read(12'hFFC, d, r);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL oor_read_top got=%h required 0", d); end
        axi_read(12'h000, d, r);
        checks++;
        if (d !== 32'd1) begin errors++; $display("FAIL oor_no_alias got=%h required 1", d); end
    endtask

    task automatic test_inference();
        int beats, lat;
        logic df;
        logic [31:0] af;
        run_stream(32'd0, 32'd1, beats, lat, df, af);
        checks++;
        if (beats != 784) begin errors++; $display("FAIL inf_beats got=%0d required 784", beats); end
        checks++;
        if (lat != 3) begin errors++; $display("FAIL inf_done_latency got=%0d required 3", lat); end
        checks++;
        if (a_tdata !== 32'h0004B208) begin errors++; $display("FAIL inf_a got=%h required 0004B208", a_tdata); end
        checks++;
        if (dut.acc !== 64'd307720) begin errors++; $display("FAIL inf_acc got=%0d required 307720", dut.acc); end
    endtask

    task automatic test_back_to_back();
        int beats, lat;
        logic df;
        logic [31:0] af;
        run_stream(32'd5, 32'd1, beats, lat, df, af);
        checks++;
        if (df !== 1'b0) begin errors++; $display("FAIL b2b_done_drop got=%b required 0", df); end
        checks++;
        if (af !== 32'h0004B208) begin errors++; $display("FAIL b2b_a_held got=%h required 0004B208", af); end
        checks++;
        if (beats != 784 || lat != 3) begin
            errors++; $display("FAIL b2b_beats_lat got=%0d/%0d required 784/3", beats, lat);
        end
        checks++;
        if (dut.acc !== 64'd307725 || a_tdata !== 32'h0004B20D) begin
            errors++; $display("FAIL b2b_result acc=%0d a=%h required 307725 0004B20D", dut.acc, a_tdata);
        end
        start = 1'b0; x_tvalid = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if (done !== 1'b1 || a_tdata !== 32'h0004B20D || x_tready !== 1'b0) begin
            errors++; $display("FAIL done_hold done=%b a=%h rdy=%b required 1 0004B20D 0", done, a_tdata, x_tready);
        end
    endtask

    task automatic test_mid_reset();
        int beats = 0, lat, n = 0;
        logic df;
        logic [31:0] af;
        bias = 32'd0; x_tdata = 32'd1; start = 1'b1; x_tvalid = 1'b1;
        while (beats < 100 && n < 500) begin
            @(negedge clk); n++;
            if (x_tvalid && x_tready) beats++;
        end
        rst = 1'b1;
        #1;
        checks++;
        if (done !== 1'b0 || x_tready !== 1'b0 || a_tdata !== 32'h0 || dut.acc !== 64'h0) begin
            errors++;
            $display("FAIL midreset done=%b rdy=%b a=%h acc=%h required 0", done, x_tready, a_tdata, dut.acc);
        end
        start = 1'b0; x_tvalid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (done !== 1'b0 || x_tready !== 1'b0) begin
            errors++; $display("FAIL midreset_idle done=%b rdy=%b required 0 0", done, x_tready);
        end
        run_stream(32'd0, 32'd1, beats, lat, df, af);
        checks++;
        if (beats != 784 || a_tdata !== 32'h0004B208 || dut.acc !== 64'd307720) begin
            errors++;
            $display("FAIL midreset_rerun beats=%0d a=%h acc=%0d required 784 0004B208 307720", beats, a_tdata, dut.acc);
        end
        start = 1'b0; x_tvalid = 1'b0;
    endtask

    task automatic test_clamp();
        int beats, lat, bad;
        logic df;
        logic [31:0] af;
        load_weights(32'hFFFFFFFF, 32'd0, bad);
        run_stream(32'd0, 32'd1, beats, lat, df, af);
        checks++;
        if (dut.acc !== 64'hFFFF_FFFF_FFFF_FCF0 || a_tdata !== 32'h0) begin
            errors++; $display("FAIL neg_clamp acc=%h a=%h required FFFFFFFFFFFFFCF0 0", dut.acc, a_tdata);
        end
        start = 1'b0; x_tvalid = 1'b0;
        load_weights(32'h7FFFFFFF, 32'd0, bad);
        run_stream(32'd0, 32'd1, beats, lat, df, af);
        checks++;
        if (dut.acc !== 64'd1683627179248 || a_tdata !== 32'h7FFFFFFF) begin
            errors++; $display("FAIL sat_clamp acc=%0d a=%h required 1683627179248 7FFFFFFF", dut.acc, a_tdata);
        end
        start = 1'b0; x_tvalid = 1'b0;
        @(negedge clk);
        run_stream(32'hFFFFFFF6, 32'd0, beats, lat, df, af);
        checks++;
        if (dut.acc !== 64'hFFFF_FFFF_FFFF_FFF6 || a_tdata !== 32'h0) begin
            errors++; $display("FAIL neg_bias acc=%h a=%h required FFFFFFFFFFFFFFF6 0", dut.acc, a_tdata);
        end
        start = 1'b0; x_tvalid = 1'b0;
        @(negedge clk);
        run_stream(32'h7FFFFFFF, 32'd0, beats, lat, df, af);
        checks++;
        if (dut.acc !== 64'h7FFFFFFF || a_tdata !== 32'h7FFFFFFF) begin
            errors++; $display("FAIL max_exact acc=%h a=%h required 7FFFFFFF 7FFFFFFF", dut.acc, a_tdata);
        end
        start = 1'b0; x_tvalid = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b1;
        araddr = '0; arvalid = 1'b0; rready = 1'b1;
        start = 1'b0; x_tdata = '0; x_tvalid = 1'b0; bias = '0;
        test_reset();
        test_axi();
        test_inference();
        test_back_to_back();
        test_mid_reset();
        test_clamp();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog_timeout checks=%0d required completion before 3ms", checks);
        $fatal(1, "watchdog");
    end
endmodule
